// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial bit-pattern detector with a run-time loadable pattern and a saturating
// match counter. Valid input bits are shifted into a PAT_W-bit history register
// (newest bit at the LSB). A fill counter tracks how many valid bits the history
// holds since the last reset/pattern load (or since the last match in
// non-overlapping mode), so a match is only reported once the history is full.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  reset value of the pattern register, MSB is the oldest bit
//   OVERLAP  1: trailing bits of a match may start the next match
//            0: a match restarts collection from zero bits
//   CNT_W    width of the match counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in         serial data bit
//   in_valid   in is sampled on this edge
//   pat_load   load pat_value into the pattern register, clear history/fill
//   pat_value  new pattern, MSB oldest
//   clr_cnt    synchronous clear of match_cnt and cnt_sat
//   out        registered one-cycle match pulse
//   match_cnt  saturating count of matches
//   cnt_sat    sticky flag, set once match_cnt reaches its maximum
// -----------------------------------------------------------------------------
module seq_detect_param #(
   parameter int unsigned      PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter bit               OVERLAP = 1'b1,
   parameter int unsigned      CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_value,
   input  logic             clr_cnt,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   // Fill has to represent 0..PAT_W inclusive.
   localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [PAT_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic              out_q, out_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sat_q, sat_d;

   logic [PAT_W-1:0]  hist_shift;
   logic [FILL_W-1:0] fill_inc;
   logic              match;
   logic [CNT_W-1:0]  cnt_base;
   logic              sat_base;

   // ---------------------------------------------------------------------------
   // Match detection, evaluated on the post-shift view of history and fill.
   // ---------------------------------------------------------------------------
   always_comb begin
      hist_shift = {hist_q[PAT_W-2:0], in};
      fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      // pat_load wins over in_valid: the concurrent bit never reaches the history.
      match      = in_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_shift == pat_q);
   end

   // ---------------------------------------------------------------------------
   // History, fill and pattern next state.
   // ---------------------------------------------------------------------------
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      if (pat_load) begin
         pat_d  = pat_value;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = hist_shift;
         // In non-overlapping mode only fill needs clearing; stale history bits
         // cannot cause a match until PAT_W fresh bits have replaced them.
         fill_d = (match && !OVERLAP) ? '0 : fill_inc;
      end
   end

   // ---------------------------------------------------------------------------
   // Match pulse and saturating counter. A clear coinciding with a match is
   // applied first, so the match is counted on top of the cleared value.
   // ---------------------------------------------------------------------------
   always_comb begin
      out_d    = match;
      cnt_base = clr_cnt ? '0   : cnt_q;
      sat_base = clr_cnt ? 1'b0 : sat_q;
      cnt_d    = cnt_base;
      sat_d    = sat_base;
      if (match) begin
         if (cnt_base != CNT_MAX) begin
            cnt_d = cnt_base + 1'b1;
         end
         if (cnt_d == CNT_MAX) begin
            sat_d = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= PATTERN;
         out_q  <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
      end
   end

   assign out       = out_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule
